// File: rtl/instr_encoder_pkg.sv
// Shared constants for the RV32I instruction encoder: request kind codes,
// base opcodes, funct fields and the encoder FSM state type.
package instr_encoder_pkg;

    localparam logic [4:0] K_ADD   = 5'd0;
    localparam logic [4:0] K_SUB   = 5'd1;
    localparam logic [4:0] K_AND   = 5'd2;
    localparam logic [4:0] K_OR    = 5'd3;
    localparam logic [4:0] K_XOR   = 5'd4;
    localparam logic [4:0] K_SLL   = 5'd5;
    localparam logic [4:0] K_SRL   = 5'd6;
    localparam logic [4:0] K_SRA   = 5'd7;
    localparam logic [4:0] K_SLT   = 5'd8;
    localparam logic [4:0] K_SLTU  = 5'd9;
    localparam logic [4:0] K_ADDI  = 5'd10;
    localparam logic [4:0] K_ANDI  = 5'd11;
    localparam logic [4:0] K_ORI   = 5'd12;
    localparam logic [4:0] K_XORI  = 5'd13;
    localparam logic [4:0] K_SLTI  = 5'd14;
    localparam logic [4:0] K_SLTIU = 5'd15;
    localparam logic [4:0] K_SLLI  = 5'd16;
    localparam logic [4:0] K_SRLI  = 5'd17;
    localparam logic [4:0] K_SRAI  = 5'd18;
    localparam logic [4:0] K_LW    = 5'd19;
    localparam logic [4:0] K_SW    = 5'd20;
    localparam logic [4:0] K_BEQ   = 5'd21;
    localparam logic [4:0] K_LUI   = 5'd22;
    localparam logic [4:0] K_JAL   = 5'd23;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_SW   = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_WR   = 2'd2
    } state_e;

    // ALU funct3 shared by the register and immediate forms of an op.
    function automatic logic [2:0] kind_f3(input logic [4:0] kind);
        logic [2:0] f3;
        f3 = F3_ADD;
        case (kind)
            K_AND, K_ANDI:   f3 = F3_AND;
            K_OR, K_ORI:     f3 = F3_OR;
            K_XOR, K_XORI:   f3 = F3_XOR;
            K_SLL, K_SLLI:   f3 = F3_SLL;
            K_SRL, K_SRLI,
            K_SRA, K_SRAI:   f3 = F3_SR;
            K_SLT, K_SLTI:   f3 = F3_SLT;
            K_SLTU, K_SLTIU: f3 = F3_SLTU;
            default:         f3 = F3_ADD;
        endcase
        return f3;
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational RV32I packer: turns a symbolic request into a machine word
// and flags whether the immediate fits the chosen format.
module rv32i_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    logic       fits12;
    logic       fits13;
    logic       fits21;
    logic [2:0] f3;
    logic [6:0] f7;

    // A value fits N signed bits when all bits above N-1 equal the sign.
    assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

    assign f3 = kind_f3(kind);
    assign f7 = (kind == K_SUB || kind == K_SRA || kind == K_SRAI)
              ? F7_ALT : F7_BASE;

    always_comb begin
        word  = '0;
        legal = 1'b0;
        case (kind)
            K_ADD, K_SUB, K_AND, K_OR, K_XOR,
            K_SLL, K_SRL, K_SRA, K_SLT, K_SLTU: begin
                legal = 1'b1;
                word  = {f7, rs2, rs1, f3, rd, OP_R};
            end
            K_ADDI, K_ANDI, K_ORI, K_XORI, K_SLTI, K_SLTIU: begin
                legal = fits12;
                word  = {imm[11:0], rs1, f3, rd, OP_IMM};
            end
            K_SLLI, K_SRLI, K_SRAI: begin
                legal = ~(|imm[31:5]);
                word  = {f7, imm[4:0], rs1, f3, rd, OP_IMM};
            end
            K_LW: begin
                legal = fits12;
                word  = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
            end
            K_SW: begin
                legal = fits12;
                word  = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
            end
            K_BEQ: begin
                legal = fits13 & ~imm[0];
                word  = {imm[12], imm[10:5], rs2, rs1, F3_BEQ,
                         imm[4:1], imm[11], OP_BR};
            end
            K_LUI: begin
                legal = ~(|imm[11:0]);
                word  = {imm[31:12], rd, OP_LUI};
            end
            K_JAL: begin
                legal = fits21 & ~imm[0];
                word  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            default: begin
                legal = 1'b0;
                word  = '0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequential instruction encoder: accepts a request, packs it, and writes
// the word to the next instruction-memory address (IDLE -> ENC -> WR).
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_kind,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [31:0]       req_imm,
    input  logic              flush,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam int              CAP   = (1 << ADDR_W) - BASE_ADDR;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAP_W = (ADDR_W + 1)'(CAP);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic [4:0]          kind_q, kind_d;
    logic [4:0]          rd_q, rd_d;
    logic [4:0]          rs1_q, rs1_d;
    logic [4:0]          rs2_q, rs2_d;
    logic [31:0]         imm_q, imm_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         pk_word;
    logic                pk_legal;

    rv32i_pack u_pack (
        .kind  (kind_q),
        .rd    (rd_q),
        .rs1   (rs1_q),
        .rs2   (rs2_q),
        .imm   (imm_q),
        .word  (pk_word),
        .legal (pk_legal)
    );

    assign full      = (count_q == CAP_W);
    assign req_ready = (state_q == S_IDLE) & ~full;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        err_d   = err_q;
        kind_d  = kind_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        imm_d   = imm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    kind_d  = req_kind;
                    rd_d    = req_rd;
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    imm_d   = req_imm;
                    state_d = S_ENC;
                end
            end
            S_ENC: begin
                if (pk_legal) begin
                    we_d    = 1'b1;
                    addr_d  = wptr_q;
                    wdata_d = pk_word;
                    state_d = S_WR;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_WR: begin
                wptr_d  = wptr_q + ADDR_W'(1);
                count_d = count_q + (ADDR_W + 1)'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
            wptr_d  = BASE;
            count_d = '0;
            err_d   = 1'b0;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            wptr_q  <= BASE;
            count_q <= '0;
            err_q   <= 1'b0;
            kind_q  <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            err_q   <= err_d;
            kind_q  <= kind_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // A flush landing in the write cycle cancels the strobe immediately.
    assign im_we    = we_q & ~flush;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign count    = count_q;
    assign err      = err_q;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder and instruction-memory writer for the single-cycle CPU simulation environment. It accepts symbolic instruction requests (kind, register indices, full-width immediate) over a valid/ready handshake. It range-checks the request, packs the 32-bit machine word, and writes it to consecutive instruction-memory word addresses. The block is the inverse of the CPU's control decoder and is used to build test programs in-simulation before the CPU is released from reset.

## Interface
Parameters:
- ADDR_W, 7: instruction-memory word-address width (depth 2^ADDR_W).
- BASE_ADDR, 0: word address of the first write after reset or flush.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_kind  in  5  instruction kind code from the shared package (ADD..SLTU, ADDI..SRAI, LW, SW, BEQ, LUI, JAL).
- req_rd, req_rs1, req_rs2  in  5 each  register indices; unused fields are ignored.
- req_imm  in  32  immediate as a full signed byte value; LUI takes the full upper value.
- flush  in  1  rewinds the write pointer to BASE_ADDR and clears err.
- im_we  out  1  instruction-memory write strobe.
- im_addr  out  ADDR_W  word address.
- im_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  number of words written since reset/flush.
- full  out  1  count == 2^ADDR_W - BASE_ADDR.
- err  out  1  sticky: an illegal request was dropped.

## Operation
- FSM states: IDLE, ENC, WR.
  - IDLE: req_ready = ~full. On req_valid & req_ready, latch the request fields and go to ENC.
  - ENC: pack the word and check legality.
    - Legal: register the word and go to WR.
    - Illegal: set err, go to IDLE, no write.
  - WR: im_we = 1, im_addr = wptr, im_wdata = registered word. At the edge, wptr++ and count++, then go to IDLE.
- Legality rules:
  - I-type (ADDI, ANDI, ORI, XORI, SLTI, SLTIU, LW) and S-type: req_imm must be in [-2048, 2047].
  - Shifts (SLLI, SRLI, SRAI): req_imm[31:5] == 0.
  - BEQ: req_imm in [-4096, 4094] and req_imm[0] == 0.
  - JAL: req_imm in [-2^20, 2^20-2] and req_imm[0] == 0.
  - LUI: req_imm[11:0] == 0.
  - Unused kind codes are illegal.
- Packing: standard RV32I formats.
  - R-type: funct7 = 0x20 for SUB and SRA, 0x00 otherwise.
  - SRAI: imm[11:5] = 0x20.
  - LW and SW use funct3 = 010. BEQ uses funct3 = 000.
- flush: takes effect in any state. It forces IDLE, sets wptr = BASE_ADDR, count = 0, err = 0, and kills any pending write (im_we = 0 in that cycle).
- No wrap-around. Once full, req_ready stays 0 until flush or rst.

## Timing
- Reset values: state IDLE, wptr BASE_ADDR, count 0, err 0, im_we 0, im_addr BASE_ADDR, im_wdata 0, full 0. req_ready is 1 unless full (only possible when 2^ADDR_W - BASE_ADDR == 0).
- Request accepted at edge N. ENC occupies cycle N..N+1. im_we is high for exactly one cycle, between edges N+1 and N+2. req_ready returns high after edge N+2.
- Throughput: one word per 3 cycles.
- Illegal request: err rises at edge N+1 and req_ready returns high after edge N+1.
- im_we, im_addr and im_wdata are registered or state-decoded only. There are no combinational paths from req_* to im_*.
- req_ready does not depend combinationally on req_valid.
- flush and rst in the same cycle: rst dominates, with the same result.
- rst asserted mid-WR: im_we drops asynchronously and the word is not written.

## Structure
- Shared package instr_encoder_pkg holds:
  - kind codes (5-bit localparams);
  - opcode constants 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111;
  - funct3/funct7 constants;
  - FSM state encoding.
- Sub-module: rv32i_pack, purely combinational, takes (kind, rd, rs1, rs2, imm) and returns (word, legal). The top module holds the FSM, pointer, counters and handshake.

## Test plan
- After reset, send ADD rd=1 rs1=2 rs2=3 → im_we pulse at addr 0 with 0x003100B3; count = 1.
- Back-to-back stream of ADDI x5,x0,-1; SW x2,8(x1); BEQ x1,x2,-4 → 0xFFF00293, 0x0020A423, 0xFE208EE3 at addrs 0, 1, 2, each im_we 3 cycles apart.
- LUI x3,0x12345000; JAL x1,8; SRAI x4,x4,3 → 0x123451B7, 0x008000EF, 0x40325213.
- Illegal requests ADDI imm=2048, BEQ imm=3, LUI imm=0x123 → no im_we, err = 1, count unchanged. flush clears err and count.
- ADDR_W=2: write 4 words → full = 1 and req_ready = 0, a 5th request is held. Then flush → next word is written at addr 0.
- rst asserted during WR → im_we drops immediately, count = 0, and next write goes to BASE_ADDR.
